// File: rtl/crtc_pkg.sv
// Shared constants for the CRTC register file: bus decode addresses,
// register count, register index names and the per-register width table
// used when CRTC_REG_MASK_EN is defined.
package crtc_pkg;

   localparam logic [16:0] CRTC_ADDR_REG = 17'h0E880;
   localparam logic [16:0] CRTC_DATA_REG = 17'h0E881;

   localparam int NUM_REGS = 18;

   localparam int R_H_TOTAL      = 0;
   localparam int R_H_DISPLAYED  = 1;
   localparam int R_H_SYNC_POS   = 2;
   localparam int R_SYNC_WIDTH   = 3;
   localparam int R_V_TOTAL      = 4;
   localparam int R_V_TOTAL_ADJ  = 5;
   localparam int R_V_DISPLAYED  = 6;
   localparam int R_V_SYNC_POS   = 7;
   localparam int R_MODE         = 8;
   localparam int R_SCAN_LINE    = 9;
   localparam int R_CURSOR_START = 10;
   localparam int R_CURSOR_END   = 11;
   localparam int R_START_H      = 12;
   localparam int R_START_L      = 13;
   localparam int R_CURSOR_H     = 14;
   localparam int R_CURSOR_L     = 15;
   localparam int R_LPEN_H       = 16;
   localparam int R_LPEN_L       = 17;

   // Implemented-bit mask of each 6545 register; unknown indices hold nothing.
   function automatic logic [7:0] reg_mask(input int idx);
      logic [7:0] m;
      case (idx)
         R_H_TOTAL, R_H_DISPLAYED, R_H_SYNC_POS, R_SYNC_WIDTH: m = 8'hFF;
         R_V_TOTAL, R_V_DISPLAYED, R_V_SYNC_POS:               m = 8'h7F;
         R_V_TOTAL_ADJ:                                        m = 8'h1F;
         R_MODE:                                               m = 8'h03;
         R_SCAN_LINE:                                          m = 8'h1F;
         R_CURSOR_START:                                       m = 8'h7F;
         R_CURSOR_END:                                         m = 8'h1F;
         R_START_H, R_CURSOR_H:                                m = 8'h3F;
         R_START_L, R_CURSOR_L, R_LPEN_H, R_LPEN_L:            m = 8'hFF;
         default:                                              m = 8'h00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/crtc_reg_file_address_decoding.sv
// CPU bus sub-decoder: flags any address in the $E880-$E8FF block
// (address/data ports mirrored every two bytes).
module address_decoding
   import crtc_pkg::*;
(
   input  logic [16:0] bus_addr,
   output logic        crtc_enable
);

   localparam logic [16:0] SEL_MASK = 17'h1FF80;

   assign crtc_enable = ((bus_addr & SEL_MASK) == (CRTC_ADDR_REG & SEL_MASK));

endmodule

// File: rtl/crtc_reg_file.sv
// CRTC register file: CPU address/data ports, Pi read/write window and
// exported selection for the video timing logic.
// Optional macro CRTC_REG_MASK_EN masks stored values to 6545 widths.
module crtc_reg_file
   import crtc_pkg::*;
#(
   parameter logic [15:0] PI_BASE = 16'hE8E0
) (
   input  logic        clk16,
   input  logic        res_b,
   input  logic [16:0] bus_addr,
   input  logic [7:0]  bus_data_in,
   input  logic        cpu_write,
   input  logic [15:0] pi_addr,
   input  logic [7:0]  pi_data_in,
   input  logic        pi_read,
   input  logic        pi_write,
   output logic [7:0]  crtc_data_out,
   output logic        crtc_data_out_enable,
   output logic [4:0]  crtc_address_register,
   output logic [7:0]  crtc_r
);

   logic       crtc_select_s;
   logic       cpu_addr_wr_s;
   logic       cpu_data_wr_s;
   logic       pi_hit_s;
   logic [4:0] pi_index_s;
   logic       pi_rd_s;
   logic       pi_wr_s;
   logic [7:0] sel_val_s;
   logic [7:0] pi_val_s;
   logic [7:0] mask_s [NUM_REGS];

   logic [7:0] regs_r [NUM_REGS];
   logic [4:0] addr_reg_r;
   logic [7:0] data_out_r;

   address_decoding u_address_decoding (
      .bus_addr    (bus_addr),
      .crtc_enable (crtc_select_s)
   );

   assign cpu_addr_wr_s = cpu_write && crtc_select_s && !bus_addr[0];
   assign cpu_data_wr_s = cpu_write && crtc_select_s &&  bus_addr[0];
   assign pi_hit_s      = (pi_addr[15:5] == PI_BASE[15:5]);
   assign pi_index_s    = pi_addr[4:0];
   assign pi_rd_s       = pi_read  && pi_hit_s;
   assign pi_wr_s       = pi_write && pi_hit_s;

   // Per-register store mask: full byte unless width masking is built in.
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
`ifdef CRTC_REG_MASK_EN
         mask_s[i] = reg_mask(i);
`else
         mask_s[i] = 8'hFF;
`endif
      end
   end

   // Read muxes for the CPU selection and the Pi index; out-of-range reads 0.
   always_comb begin
      sel_val_s = 8'h00;
      pi_val_s  = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (addr_reg_r == 5'(i)) begin
            sel_val_s = regs_r[i];
         end else begin
            sel_val_s = sel_val_s;
         end
         if (pi_index_s == 5'(i)) begin
            pi_val_s = regs_r[i];
         end else begin
            pi_val_s = pi_val_s;
         end
      end
   end

   // Address register: CPU write to the even port selects a register.
   always_ff @(posedge clk16 or negedge res_b) begin
      if (!res_b) begin
         addr_reg_r <= 5'd0;
      end else if (cpu_addr_wr_s) begin
         addr_reg_r <= bus_data_in[4:0];
      end else begin
         addr_reg_r <= addr_reg_r;
      end
   end

   // Register array: CPU data write takes priority over a Pi write to the same slot.
   always_ff @(posedge clk16 or negedge res_b) begin
      if (!res_b) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 8'h00;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (cpu_data_wr_s && (addr_reg_r == 5'(i))) begin
               regs_r[i] <= bus_data_in & mask_s[i];
            end else if (pi_wr_s && (pi_index_s == 5'(i))) begin
               regs_r[i] <= pi_data_in & mask_s[i];
            end else begin
               regs_r[i] <= regs_r[i];
            end
         end
      end
   end

   // Pi read-back latch: captures the pre-write value and holds until the next read.
   always_ff @(posedge clk16 or negedge res_b) begin
      if (!res_b) begin
         data_out_r <= 8'h00;
      end else if (pi_rd_s) begin
         data_out_r <= pi_val_s;
      end else begin
         data_out_r <= data_out_r;
      end
   end

   assign crtc_data_out         = data_out_r;
   assign crtc_data_out_enable  = pi_hit_s;
   assign crtc_address_register = addr_reg_r;
   assign crtc_r                = sel_val_s;

endmodule

// File: tb/tb_crtc_reg_file.sv
// Scoreboard bench for crtc_reg_file: stimulus updates a behavioural model
// and queues expected outputs; a monitor compares them after each edge.
module tb_crtc_reg_file;

   logic        clk16;
   logic        res_b;
   logic [16:0] bus_addr;
   logic [7:0]  bus_data_in;
   logic        cpu_write;
   logic [15:0] pi_addr;
   logic [7:0]  pi_data_in;
   logic        pi_read;
   logic        pi_write;
   logic [7:0]  crtc_data_out;
   logic        crtc_data_out_enable;
   logic [4:0]  crtc_address_register;
   logic [7:0]  crtc_r;

   crtc_reg_file #(.PI_BASE(16'hE8E0)) dut (
      .clk16                 (clk16),
      .res_b                 (res_b),
      .bus_addr              (bus_addr),
      .bus_data_in           (bus_data_in),
      .cpu_write             (cpu_write),
      .pi_addr               (pi_addr),
      .pi_data_in            (pi_data_in),
      .pi_read               (pi_read),
      .pi_write              (pi_write),
      .crtc_data_out         (crtc_data_out),
      .crtc_data_out_enable  (crtc_data_out_enable),
      .crtc_address_register (crtc_address_register),
      .crtc_r                (crtc_r)
   );

   initial begin
      clk16 = 1'b0;
      forever #5 clk16 = ~clk16;
   end

   typedef struct {
      int    stamp;
      int    sig;
      int    exp;
      string name;
   } chk_t;

   chk_t q[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   // Behavioural model of the register file
   int m_regs [18];
   int m_sel;
   int m_dout;

   function automatic int width_mask(input int idx);
`ifdef CRTC_REG_MASK_EN
      int w [18] = '{8, 8, 8, 8, 7, 5, 7, 7, 2, 5, 7, 5, 6, 8, 6, 8, 8, 8};
      return (1 << w[idx]) - 1;
`else
      return idx * 0 + 255;
`endif
   endfunction

   // Monitor: one posedge+1 sample per cycle, compares every entry due now.
   always @(posedge clk16) begin
      chk_t c;
      int   act;
      #1;
      cyc++;
      while (q.size() > 0 && q[0].stamp <= cyc) begin
         c = q.pop_front();
         case (c.sig)
            0:       act = int'(crtc_data_out);
            1:       act = int'(crtc_data_out_enable);
            2:       act = int'(crtc_address_register);
            default: act = int'(crtc_r);
         endcase
         total++;
         if (c.stamp < cyc || act != c.exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", c.name, cyc, act, c.exp);
         end
      end
   end

   task automatic push(input int sig, input int exp, input string name);
      chk_t c;
      c.stamp = cyc + 1;
      c.sig   = sig;
      c.exp   = exp;
      c.name  = name;
      q.push_back(c);
   endtask

   // One clock of stimulus; model applied with the spec's priority rules.
   task automatic txn(input bit rst, input logic [16:0] ba, input logic [7:0] bd,
                      input bit cw, input logic [15:0] pa, input logic [7:0] pd,
                      input bit pr, input bit pw);
      bit cpu_sel;
      bit pi_in;
      int pidx;
      int old_sel;
      res_b       = !rst;
      bus_addr    = ba;
      bus_data_in = bd;
      cpu_write   = cw;
      pi_addr     = pa;
      pi_data_in  = pd;
      pi_read     = pr;
      pi_write    = pw;
      cpu_sel = (int'(ba) >= 'hE880) && (int'(ba) <= 'hE8FF);
      pi_in   = (int'(pa) >= 'hE8E0) && (int'(pa) <= 'hE8FF);
      pidx    = int'(pa) - 'hE8E0;
      if (rst) begin
         for (int i = 0; i < 18; i++) m_regs[i] = 0;
         m_sel  = 0;
         m_dout = 0;
      end else begin
         old_sel = m_sel;
         if (pr && pi_in) m_dout = (pidx < 18) ? m_regs[pidx] : 0;
         if (pw && pi_in && pidx < 18) m_regs[pidx] = int'(pd) & width_mask(pidx);
         if (cw && cpu_sel && (int'(ba) % 2 == 1) && old_sel < 18)
            m_regs[old_sel] = int'(bd) & width_mask(old_sel);
         if (cw && cpu_sel && (int'(ba) % 2 == 0)) m_sel = int'(bd) % 32;
      end
      push(0, m_dout, "data_out");
      push(1, int'(pi_in), "data_out_enable");
      push(2, m_sel, "address_register");
      push(3, (m_sel < 18) ? m_regs[m_sel] : 0, "crtc_r");
      @(posedge clk16);
      #2;
   endtask

   task automatic idle(input logic [15:0] pa);
      txn(1'b0, 17'h00000, 8'h00, 1'b0, pa, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic cpu_wr(input logic [16:0] ba, input logic [7:0] bd);
      txn(1'b0, ba, bd, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic pi_rd(input logic [15:0] pa);
      txn(1'b0, 17'h00000, 8'h00, 1'b0, pa, 8'h00, 1'b1, 1'b0);
   endtask

   initial begin
      logic [16:0] ba;
      logic [7:0]  bd;
      logic [15:0] pa;
      res_b = 1'b0; bus_addr = 17'h0; bus_data_in = 8'h0; cpu_write = 1'b0;
      pi_addr = 16'h0; pi_data_in = 8'h0; pi_read = 1'b0; pi_write = 1'b0;
      for (int i = 0; i < 18; i++) m_regs[i] = 0;
      m_sel = 0; m_dout = 0;
      @(posedge clk16);
      #2;

      // Reset state, then Pi reads of every register
      txn(1'b1, 17'h0, 8'h0, 1'b0, 16'hE8E0, 8'h0, 1'b0, 1'b0);
      for (int r = 0; r < 18; r++) pi_rd(16'hE8E0 + 16'(r));

      // CPU select/write each register, Pi read-back, enable held after read
      for (int r = 0; r < 18; r++) begin
         cpu_wr(17'h0E880, 8'(r));
         cpu_wr(17'h0E881, 8'h80 | 8'(r));
         pi_rd(16'hE8E0 + 16'(r));
         idle(16'hE8E0 + 16'(r));
      end

      // Out-of-range selection
      cpu_wr(17'h0E880, 8'd20);
      cpu_wr(17'h0E881, 8'h55);
      pi_rd(16'hE8F4);

      // Pi write R12, CPU select it, then collision where CPU wins
      txn(1'b0, 17'h0, 8'h0, 1'b0, 16'hE8EC, 8'h3C, 1'b0, 1'b1);
      cpu_wr(17'h0E880, 8'd12);
      txn(1'b0, 17'h0E881, 8'hAA, 1'b1, 16'hE8EC, 8'h11, 1'b0, 1'b1);
      pi_rd(16'hE8EC);

      // Read concurrent with a write returns the old value
      cpu_wr(17'h0E880, 8'd5);
      txn(1'b0, 17'h0E881, 8'h77, 1'b1, 16'hE8E5, 8'h00, 1'b1, 1'b0);
      pi_rd(16'hE8E5);

      // Outside both windows, upper address bits ignored on the selection byte
      pi_rd(16'hE900);
      cpu_wr(17'h0E780, 8'h03);
      cpu_wr(17'h0E881 + 17'h00010, 8'h5A);
      cpu_wr(17'h0E8FE, 8'hE7);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0:       ba = 17'h0E880;
            1:       ba = 17'h0E881;
            2:       ba = 17'h0E880 + 17'($urandom_range(0, 127));
            default: ba = 17'($urandom);
         endcase
         bd = (ba[0] == 1'b0) ? 8'($urandom_range(0, 21)) : 8'($urandom);
         pa = ($urandom_range(0, 3) != 0) ? 16'hE8E0 + 16'($urandom_range(0, 31))
                                          : 16'($urandom);
         txn(($urandom_range(0, 63) == 0), ba, bd, 1'($urandom), pa, 8'($urandom),
             1'($urandom), 1'($urandom));
      end

      // Reset mid-access, then everything reads zero
      cpu_wr(17'h0E880, 8'd3);
      cpu_wr(17'h0E881, 8'h42);
      txn(1'b1, 17'h0E881, 8'h99, 1'b1, 16'hE8E3, 8'h66, 1'b1, 1'b1);
      for (int r = 0; r < 18; r++) pi_rd(16'hE8E0 + 16'(r));

      repeat (4) @(posedge clk16);
      #3;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/crtc_reg_file.md
Name: crtc_reg_file

Overview:
- Register-file front end of the PET's 6545-style CRTC.
- The CPU selects a register through the address register at $E880 and writes it through the data port at $E881.
- The Raspberry Pi side can read back or write any register through a private 32-byte window.
- The current selection and the selected register value are exported for the video timing logic.

Parameters:
- NUM_REGS, 18, number of implemented CRTC registers R0..R17.
- PI_BASE, 16'hE8E0, base of the 32-byte Pi access window (must be 32-aligned).

Ports:
- clk16  in  1  system clock; all state updates on the rising edge.
- res_b  in  1  asynchronous active-low reset.
- bus_addr  in  17  CPU bus address.
- bus_data_in  in  8  CPU write data.
- cpu_write  in  1  one-clock CPU write strobe.
- pi_addr  in  16  Pi address.
- pi_data_in  in  8  Pi write data.
- pi_read  in  1  Pi read strobe.
- pi_write  in  1  Pi write strobe.
- crtc_data_out  out  8  Pi read-back data.
- crtc_data_out_enable  out  1  high while pi_addr is inside the Pi window.
- crtc_address_register  out  5  current CPU register selection.
- crtc_r  out  8  value of the currently selected register.

Behaviour:
- Sub-decoder: crtc_select = (bus_addr[16:7] == 17'h0E880 >> 7), i.e. $E880-$E8FF with mirrors. bus_addr[0] picks the port: 0 = address register, 1 = data register.
- Reset (res_b low, asynchronous):
  - all R0..R17 = 8'h00;
  - crtc_address_register = 0;
  - crtc_data_out = 8'h00.
- CPU address write: on the clk16 edge with cpu_write && crtc_select && !bus_addr[0], crtc_address_register <= bus_data_in[4:0]. Bits [7:5] are ignored.
- CPU data write: on the clk16 edge with cpu_write && crtc_select && bus_addr[0]:
  - R[crtc_address_register] <= bus_data_in;
  - ignored if crtc_address_register >= NUM_REGS.
- crtc_r is combinational: R[crtc_address_register], or 8'h00 if the index >= NUM_REGS. An updated value is visible the same edge the write occurs.
- Pi window hit: pi_hit = (pi_addr[15:5] == PI_BASE[15:5]); index = pi_addr[4:0].
- crtc_data_out_enable = pi_hit. It is combinational and independent of pi_read, so the bus driver stays enabled for the whole access.
- Pi read: on the clk16 edge with pi_read && pi_hit, crtc_data_out <= R[index] (8'h00 if index >= NUM_REGS).
  - Data is valid from that edge onward.
  - Data is held until the next qualifying pi_read.
- Pi write: on the clk16 edge with pi_write && pi_hit, R[index] <= pi_data_in; ignored if index >= NUM_REGS.
- Simultaneous CPU data write and Pi write to the same register: the CPU value wins. Writes to different registers both take effect.
- Simultaneous pi_read and any write to the same register: the read returns the pre-write value.
- cpu_write outside the decode window has no effect.
- Reset asserted mid-access clears state immediately; no partial write survives.

Optional Feature:
- Macro: CRTC_REG_MASK_EN.
- Defined: writes are masked to 6545 implemented widths and unimplemented bits read 0.
  - R3 = 8 bits; R4, R6, R7 = 7 bits; R5 = 5 bits; R8 = 2 bits; R9 = 5 bits; R10 = 7 bits; R11 = 5 bits.
  - R12 and R14 = 6 bits; R13 and R15 = 8 bits; R16 and R17 = 8 bits.
  - R0, R1, R2 = 8 bits.
- Undefined (default): all registers store full 8 bits.

Decomposition:
- Shared package crtc_pkg:
  - CRTC_ADDR_REG = 17'h0E880 and CRTC_DATA_REG = 17'h0E881;
  - NUM_REGS;
  - register index localparams R_H_TOTAL = 0 .. R_LPEN_L = 17;
  - the width-mask constant table used by CRTC_REG_MASK_EN.
- One natural sub-module, address_decoding: combinational bus_addr -> crtc_enable.

Test Plan:
- Reset, then read via Pi at $E8E0 + r for r = 0..17 -> crtc_data_out = 8'h00 and crtc_data_out_enable = 1.
- For r = 0..17:
  - CPU writes r to $E880 -> crtc_address_register = r;
  - CPU writes 8'h80|r to $E881 -> crtc_r = 8'h80|r;
  - Pi reads $E8E0 + r -> crtc_data_out = 8'h80|r, and enable stays 1 after pi_read drops.
- CPU selects R20 and writes 8'h55 -> no register changes; crtc_r = 8'h00; a Pi read of $E8F4 returns 8'h00.
- Pi writes R12 = 8'h3C at $E8EC; CPU selects 12 -> crtc_r = 8'h3C. In the same cycle, CPU writes 8'hAA and Pi writes 8'h11 to R12 -> R12 = 8'hAA.
- pi_addr = $E900 with pi_read -> enable 0 and crtc_data_out unchanged. cpu_write at $E780 -> no state change.
- Reset pulsed after writes -> crtc_address_register = 0 and all registers read 8'h00.
